ternary_matvec_sequencer: RTL

//  Sequences one ternary matrix-vector product y = W*x per transaction: W is a

---
 rtl/ternary_matvec_sequencer_pkg.sv | 39 +++
 rtl/ternary_matvec_sequencer_row_dot.sv | 22 ++
 rtl/ternary_matvec_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/ternary_matvec_sequencer_pkg.sv
// Shared types and arithmetic helpers for the ternary matrix-vector sequencer.
// Weights are 2-bit ternary codes and vector elements are signed fixed-point codes.
package ternary_matvec_sequencer_pkg;

  localparam int D                   = 4;
  localparam int FixedPointPrecision = 8;
  localparam int AccWidth            = FixedPointPrecision + $clog2(D) + 1;

  typedef logic signed [FixedPointPrecision-1:0] fixed_point_t;
  typedef fixed_point_t [D-1:0]                  vector_t;
  typedef logic [1:0]                            ternary_t;
  typedef ternary_t [D-1:0][D-1:0]               ternary_matrix_t;
  typedef logic signed [AccWidth-1:0]            acc_t;

  localparam fixed_point_t FixedPointMax = fixed_point_t'(8'h7f);
  localparam fixed_point_t FixedPointMin = fixed_point_t'(8'h80);
  localparam acc_t         AccMax        = acc_t'(FixedPointMax);
  localparam acc_t         AccMin        = acc_t'(FixedPointMin);

  function automatic fixed_point_t saturate(input acc_t a);
    if (a > AccMax) begin
      return FixedPointMax;
    end else if (a < AccMin) begin
      return FixedPointMin;
    end else begin
      return a[FixedPointPrecision-1:0];
    end
  endfunction

  // The unused code 2'b10 must decode to 0, never to -2.
  function automatic logic signed [1:0] tern_decode(input ternary_t t);
    case (t)
      2'b01:   return 2'sb01;
      2'b11:   return 2'sb11;
      default: return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/ternary_matvec_sequencer_row_dot.sv
// Combinational exact dot product of one ternary weight row with a vector.
// Terms are sign-extended to the accumulator width, so the sum never wraps.
module ternary_row_dot
  import ternary_matvec_sequencer_pkg::*;
(
  input  vector_t  x,
  input  ternary_t [D-1:0] w,
  output acc_t     sum
);

  always_comb begin
    sum = '0;
    for (int c = 0; c < D; c++) begin
      case (tern_decode(w[c]))
        2'sb01:  sum = sum + acc_t'($signed(x[c]));
        2'sb11:  sum = sum - acc_t'($signed(x[c]));
        default: sum = sum;
      endcase
    end
  end

endmodule

// File: rtl/ternary_matvec_sequencer.sv
// Sequences y = W*x over D cycles using a single shared row dot-product lane.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module ternary_matvec_sequencer
  import ternary_matvec_sequencer_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  vector_t         x_i,
  input  ternary_matrix_t w_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output vector_t         y_o,
  output logic            busy_o,
  output logic [1:0]      dbg_state_o
);

  localparam int                RowWidth = $clog2(D);
  localparam logic [RowWidth-1:0] LastRow = RowWidth'(D - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e              state;
  logic [RowWidth-1:0] row;
  vector_t             x_q;
  ternary_matrix_t     w_q;
  vector_t             y_q;
  acc_t                row_sum;

  ternary_row_dot u_row_dot (
    .x   (x_q),
    .w   (w_q[row]),
    .sum (row_sum)
  );

  // Flush is checked before any state-specific action so it wins every race.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      row         <= '0;
      x_q         <= '0;
      w_q         <= '0;
      y_q         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else if (flush_i) begin
      state       <= IDLE;
      row         <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            x_q        <= x_i;
            w_q        <= w_i;
            row        <= '0;
            state      <= COMPUTE;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        COMPUTE: begin
          y_q[row] <= saturate(row_sum);
          if (row == LastRow) begin
            row         <= '0;
            state       <= DONE;
            out_valid_o <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          row         <= '0;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign y_o         = y_q;
  assign dbg_state_o = state;

endmodule
